// File: rtl/neuron_train_sequencer_pkg.sv
// Shared types for the neuron training sequencer: value formats, the sample
// record, the sequencer state enum and the unsigned distance helper.
package neuron_train_sequencer_pkg;

   localparam int ZW    = 8;
   localparam int N_DEF = 16;

   typedef logic        [ZW-1:0] zero2one_t;
   typedef logic signed [ZW-1:0] frac_t;

   typedef struct packed {
      zero2one_t [N_DEF-1:0] in;
      zero2one_t             exp;
   } sample_t;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      EVAL,
      DONE
   } train_state_t;

   function automatic zero2one_t absdiff_z2o(input zero2one_t a, input zero2one_t b);
      return (a >= b) ? zero2one_t'(a - b) : zero2one_t'(b - a);
   endfunction

endpackage

// File: rtl/neuron_train_sequencer_if.sv
// Valid/ready sample stream feeding the training sequencer.
interface neuron_train_sequencer_if
   import neuron_train_sequencer_pkg::*;
#(
   parameter int N = 16
);
   logic                  s_valid;
   logic                  s_ready;
   zero2one_t [N-1:0]     s_in;
   zero2one_t             s_expected;

   modport master (output s_valid, output s_in, output s_expected, input s_ready);
   modport slave  (input s_valid, input s_in, input s_expected, output s_ready);
endinterface

// File: rtl/neuron_train_sequencer_sample_buffer.sv
// Linear sample store: fills from entry 0 upwards, never wraps, and is
// emptied only by clear or reset. Read port is a plain indexed mux.
module neuron_train_sequencer_sample_buffer
   import neuron_train_sequencer_pkg::*;
#(
   parameter int N     = 16,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1),
   parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              wr_en,
   input  zero2one_t [N-1:0] wr_in,
   input  zero2one_t         wr_exp,
   input  logic [PW-1:0]     rd_idx,
   output zero2one_t [N-1:0] rd_in,
   output zero2one_t         rd_exp,
   output logic [CW-1:0]     count,
   output logic              full
);

   zero2one_t [N-1:0] buf_in  [DEPTH];
   zero2one_t         buf_exp [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic              do_write;

   assign full     = (count == CW'(DEPTH));
   assign do_write = wr_en && !full && !clear;
   assign rd_in    = buf_in[rd_idx];
   assign rd_exp   = buf_exp[rd_idx];

   // Occupancy and write pointer; clear empties the store in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (do_write) begin
         wr_ptr <= wr_ptr + PW'(1);
         count  <= count + CW'(1);
      end
   end

   // Sample storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         buf_in[wr_ptr]  <= wr_in;
         buf_exp[wr_ptr] <= wr_exp;
      end
   end

endmodule

// File: rtl/neuron_train_sequencer.sv
// Buffers training samples and replays them to the learning neuron: each
// sample is held SETTLE_CYC cycles with valid low, then evaluated for one
// cycle while the absolute error is accumulated per epoch.
module neuron_train_sequencer
   import neuron_train_sequencer_pkg::*;
#(
   parameter int N          = 16,
   parameter int DEPTH      = 8,
   parameter int SETTLE_CYC = 4,
   parameter int EPOCHS     = 16,
   parameter int ERR_TOL    = 0,
   parameter int ERRW       = ZW + $clog2(DEPTH) + 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   neuron_train_sequencer_if.slave      s_bus,
   input  logic                         start,
   input  logic                         clear,
   output logic                         busy,
   output logic                         done,
   output logic                         epoch_done,
   output logic [$clog2(EPOCHS+1)-1:0]  epoch_cnt,
   output logic [ERRW-1:0]              epoch_err,
   output logic                         n_valid,
   output logic                         n_learn,
   output zero2one_t [N-1:0]            n_in,
   output zero2one_t                    n_expected,
   input  zero2one_t                    n_out
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int EW = $clog2(EPOCHS + 1);
   localparam int SW = $clog2(SETTLE_CYC + 1);

   train_state_t      state, state_next;
   logic [SW-1:0]     settle_cnt;
   logic [PW-1:0]     rd_idx;
   logic [ERRW-1:0]   acc;
   logic [CW-1:0]     count;
   logic              full;
   zero2one_t [N-1:0] rd_in;
   zero2one_t         rd_exp;
   logic              accept;
   logic              start_empty;
   logic              settle_last;
   logic              last_sample;
   logic              stop_now;
   logic              replaying;
   zero2one_t         term;
   logic [ERRW-1:0]   new_err;

   neuron_train_sequencer_sample_buffer #(.N(N), .DEPTH(DEPTH)) u_buf (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear),
      .wr_en  (accept),
      .wr_in  (s_bus.s_in),
      .wr_exp (s_bus.s_expected),
      .rd_idx (rd_idx),
      .rd_in  (rd_in),
      .rd_exp (rd_exp),
      .count  (count),
      .full   (full)
   );

   assign s_bus.s_ready = (state == IDLE) && !full;
   assign accept        = s_bus.s_valid && s_bus.s_ready;
   assign start_empty   = (count == '0) && !accept;
   assign settle_last   = (settle_cnt == SW'(SETTLE_CYC - 1));
   assign last_sample   = (CW'(rd_idx) == count - CW'(1));
   assign term          = absdiff_z2o(n_out, rd_exp);
   assign new_err       = acc + ERRW'(term);
   assign stop_now      = (new_err <= ERRW'(ERR_TOL)) || (epoch_cnt == EW'(EPOCHS - 1));
   assign replaying     = (state == SETTLE) || (state == EVAL);
   assign n_in          = replaying ? rd_in : '0;
   assign n_expected    = replaying ? rd_exp : '0;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state selection and the neuron/status controls decoded from state.
   always_comb begin
      state_next = state;
      n_valid    = 1'b1;
      n_learn    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = start_empty ? DONE : SETTLE;
         end
         SETTLE: begin
            n_valid = 1'b0;
            n_learn = 1'b1;
            busy    = 1'b1;
            if (settle_last) state_next = EVAL;
         end
         EVAL: begin
            n_learn    = 1'b1;
            busy       = 1'b1;
            state_next = (last_sample && stop_now) ? DONE : SETTLE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_next = (count == '0) ? DONE : SETTLE;
         end
         default: state_next = IDLE;
      endcase
      if (clear) state_next = IDLE;
   end

   // Replay index, settle timer, error accumulation and epoch bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
         rd_idx     <= '0;
         acc        <= '0;
         epoch_err  <= '0;
         epoch_cnt  <= '0;
         epoch_done <= 1'b0;
      end else begin
         epoch_done <= 1'b0;
         if (clear) begin
            settle_cnt <= '0;
            rd_idx     <= '0;
            acc        <= '0;
            epoch_err  <= '0;
            epoch_cnt  <= '0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (start) begin
                     settle_cnt <= '0;
                     rd_idx     <= '0;
                     acc        <= '0;
                     epoch_err  <= '0;
                     epoch_cnt  <= '0;
                  end
               end
               SETTLE: begin
                  settle_cnt <= settle_last ? '0 : settle_cnt + SW'(1);
               end
               EVAL: begin
                  settle_cnt <= '0;
                  if (last_sample) begin
                     epoch_err  <= new_err;
                     epoch_cnt  <= epoch_cnt + EW'(1);
                     epoch_done <= 1'b1;
                     rd_idx     <= '0;
                     acc        <= '0;
                  end else begin
                     acc    <= new_err;
                     rd_idx <= rd_idx + PW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_neuron_train_sequencer.sv
// Randomised bench for the training sequencer. The neuron is stubbed by a
// selectable function of the sample; expected timing and epoch errors come
// from a sample-list model evaluated with plain arithmetic.
module tb_neuron_train_sequencer;
   import neuron_train_sequencer_pkg::*;

   localparam int N          = 4;
   localparam int DEPTH      = 4;
   localparam int SETTLE_CYC = 2;
   localparam int EPOCHS     = 3;
   localparam int ERR_TOL    = 0;
   localparam int ERRW       = ZW + $clog2(DEPTH) + 1;
   localparam int EW         = $clog2(EPOCHS + 1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              clear = 1'b0;
   logic              busy, done, epoch_done, n_valid, n_learn;
   logic [EW-1:0]     epoch_cnt;
   logic [ERRW-1:0]   epoch_err;
   zero2one_t [N-1:0] n_in;
   zero2one_t         n_expected;
   zero2one_t         n_out;
   int                stub_mode = 0;

   zero2one_t m_in  [DEPTH][N];
   zero2one_t m_exp [DEPTH];
   int        m_cnt = 0;
   int        errors = 0;
   int        checks = 0;

   neuron_train_sequencer_if #(.N(N)) s_bus ();

   neuron_train_sequencer #(
      .N(N), .DEPTH(DEPTH), .SETTLE_CYC(SETTLE_CYC),
      .EPOCHS(EPOCHS), .ERR_TOL(ERR_TOL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_bus      (s_bus.slave),
      .start      (start),
      .clear      (clear),
      .busy       (busy),
      .done       (done),
      .epoch_done (epoch_done),
      .epoch_cnt  (epoch_cnt),
      .epoch_err  (epoch_err),
      .n_valid    (n_valid),
      .n_learn    (n_learn),
      .n_in       (n_in),
      .n_expected (n_expected),
      .n_out      (n_out)
   );

   always #5 clk = ~clk;

   assign n_out = (stub_mode == 0) ? zero2one_t'(0) :
                  (stub_mode == 1) ? n_expected : n_in[0];

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int neuronGuess(input int s);
      if (stub_mode == 0) return 0;
      if (stub_mode == 1) return int'(m_exp[s]);
      return int'(m_in[s][0]);
   endfunction

   function automatic int epochSum();
      int sum = 0;
      for (int s = 0; s < m_cnt; s++) begin
         int d = neuronGuess(s) - int'(m_exp[s]);
         sum += (d < 0) ? -d : d;
      end
      return sum;
   endfunction

   task automatic pulseClear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      m_cnt = 0;
   endtask

   // Offers one sample for one cycle; the model keeps it only if room remained.
   task automatic offerSample(input bit max_exp, input bit with_start);
      zero2one_t vin [N];
      zero2one_t vexp;
      for (int j = 0; j < N; j++) begin
         vin[j] = zero2one_t'($urandom);
         s_bus.s_in[j] = vin[j];
      end
      vexp = max_exp ? zero2one_t'(8'hFF) : zero2one_t'($urandom);
      s_bus.s_expected = vexp;
      s_bus.s_valid = 1'b1;
      start = with_start;
      checkOutput("s_ready", 64'(s_bus.s_ready), 64'(m_cnt < DEPTH));
      tick();
      s_bus.s_valid = 1'b0;
      start = 1'b0;
      if (m_cnt < DEPTH) begin
         for (int j = 0; j < N; j++) m_in[m_cnt][j] = vin[j];
         m_exp[m_cnt] = vexp;
         m_cnt++;
      end
   endtask

   // Follows a replay cycle by cycle from the first SETTLE cycle to DONE.
   task automatic runReplay();
      int sum     = epochSum();
      int n_ep    = (sum <= ERR_TOL) ? 1 : EPOCHS;
      int ep_len  = m_cnt * (SETTLE_CYC + 1);
      int total   = n_ep * ep_len;
      logic [N*ZW-1:0] vec;
      for (int c = 0; c < total; c++) begin
         int phase = c % (SETTLE_CYC + 1);
         int slot  = (c / (SETTLE_CYC + 1)) % m_cnt;
         bit ep_edge = (c > 0) && (c % ep_len == 0);
         for (int j = 0; j < N; j++) vec[j*ZW +: ZW] = m_in[slot][j];
         checkOutput("busy", 64'(busy), 64'(1));
         checkOutput("n_valid", 64'(n_valid), 64'(phase == SETTLE_CYC));
         checkOutput("n_learn", 64'(n_learn), 64'(1));
         checkOutput("n_in", 64'(n_in), 64'(vec));
         checkOutput("n_expected", 64'(n_expected), 64'(m_exp[slot]));
         checkOutput("epoch_done", 64'(epoch_done), 64'(ep_edge));
         if (ep_edge) begin
            checkOutput("epoch_err_mid", 64'(epoch_err), 64'(sum));
            checkOutput("epoch_cnt_mid", 64'(epoch_cnt), 64'(c / ep_len));
         end
         tick();
      end
      checkOutput("done_end", 64'(done), 64'(1));
      checkOutput("busy_end", 64'(busy), 64'(0));
      checkOutput("epoch_done_end", 64'(epoch_done), 64'(1));
      checkOutput("epoch_cnt_end", 64'(epoch_cnt), 64'(n_ep));
      checkOutput("epoch_err_end", 64'(epoch_err), 64'(sum));
      checkOutput("n_valid_done", 64'(n_valid), 64'(1));
      checkOutput("n_learn_done", 64'(n_learn), 64'(0));
      checkOutput("s_ready_done", 64'(s_bus.s_ready), 64'(0));
      tick();
      checkOutput("epoch_done_off", 64'(epoch_done), 64'(0));
      checkOutput("done_hold", 64'(done), 64'(1));
   endtask

   // One training run: fresh buffer, k offers, start (optionally with the last offer).
   task automatic applyStimulus(input int k, input int mode, input bit max_exp, input bit same_cycle);
      pulseClear();
      stub_mode = mode;
      for (int i = 0; i < k; i++) offerSample(max_exp, same_cycle && (i == k - 1));
      if (!same_cycle) begin
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      runReplay();
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_s_ready"}, 64'(s_bus.s_ready), 64'(1));
      checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
      checkOutput({tag, "_done"}, 64'(done), 64'(0));
      checkOutput({tag, "_epoch_done"}, 64'(epoch_done), 64'(0));
      checkOutput({tag, "_epoch_cnt"}, 64'(epoch_cnt), 64'(0));
      checkOutput({tag, "_epoch_err"}, 64'(epoch_err), 64'(0));
      checkOutput({tag, "_n_valid"}, 64'(n_valid), 64'(1));
      checkOutput({tag, "_n_learn"}, 64'(n_learn), 64'(0));
      checkOutput({tag, "_n_in"}, 64'(n_in), 64'(0));
      checkOutput({tag, "_n_expected"}, 64'(n_expected), 64'(0));
   endtask

   // With an empty buffer, start must finish immediately with zero results.
   task automatic checkEmptyStart(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput({tag, "_done"}, 64'(done), 64'(1));
      checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
      checkOutput({tag, "_epoch_cnt"}, 64'(epoch_cnt), 64'(0));
      checkOutput({tag, "_epoch_err"}, 64'(epoch_err), 64'(0));
   endtask

   initial begin
      s_bus.s_valid    = 1'b0;
      s_bus.s_in       = '0;
      s_bus.s_expected = '0;

      #12;
      checkReset("reset");
      tick();
      rst_n = 1'b1;
      tick();

      checkEmptyStart("empty_start");

      applyStimulus(3, 2, 1'b0, 1'b0);
      applyStimulus(DEPTH + 1, 2, 1'b0, 1'b0);
      applyStimulus(2, 0, 1'b1, 1'b0);
      applyStimulus(3, 1, 1'b0, 1'b0);
      applyStimulus(2, 2, 1'b0, 1'b1);

      // Retrain from DONE on the retained buffer.
      stub_mode = 2;
      start = 1'b1;
      tick();
      start = 1'b0;
      runReplay();

      // clear together with start in DONE: back to IDLE with an empty buffer.
      clear = 1'b1;
      start = 1'b1;
      tick();
      clear = 1'b0;
      start = 1'b0;
      m_cnt = 0;
      checkOutput("cs_done", 64'(done), 64'(0));
      checkOutput("cs_busy", 64'(busy), 64'(0));
      checkOutput("cs_s_ready", 64'(s_bus.s_ready), 64'(1));
      checkOutput("cs_epoch_cnt", 64'(epoch_cnt), 64'(0));
      checkOutput("cs_epoch_err", 64'(epoch_err), 64'(0));
      tick();
      checkOutput("cs_idle", 64'(busy), 64'(0));
      checkEmptyStart("cs_empty");

      for (int t = 0; t < 25; t++) begin
         applyStimulus(int'($urandom_range(1, DEPTH + 1)), int'($urandom_range(0, 2)),
                       1'b0, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            runReplay();
         end
      end

      // Asynchronous reset in the middle of a SETTLE phase.
      pulseClear();
      stub_mode = 2;
      offerSample(1'b0, 1'b0);
      offerSample(1'b0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("pre_rst_n_valid", 64'(n_valid), 64'(0));
      rst_n = 1'b0;
      #1;
      checkReset("mid_rst");
      tick();
      rst_n = 1'b1;
      tick();
      m_cnt = 0;
      checkEmptyStart("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/neuron_train_sequencer.md
Name: neuron_train_sequencer

Overview:
- Upstream driver for the learning neuron.
- Buffers a small set of training samples (input vector plus expected output) arriving on a valid/ready stream, then replays them to the neuron for a configurable number of epochs.
- For each sample it holds the neuron's `valid` low for SETTLE_CYC cycles so the neuron perturbs its parameters, then raises `valid` for one evaluation cycle.
- In that evaluation cycle it scores the neuron output against the expected value and accumulates the per-epoch absolute error, with optional early stop.

Parameters:
- N, 16: neuron fan-in; width of the sample input vector.
- DEPTH, 8: sample buffer entries (≥1).
- SETTLE_CYC, 4: cycles per sample with `n_valid`=0 (≥1).
- EPOCHS, 16: maximum training epochs (≥1).
- ERR_TOL, 0: early-stop threshold on epoch error. Training stops when epoch_err ≤ ERR_TOL.
- ERRW, ZW+$clog2(DEPTH)+1: error accumulator width. ZW is the package width of zero2one_t. Sized so the sum cannot overflow, so no saturation is required.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  sample offered.
- s_ready  out  1  sample buffer can accept.
- s_in  in  zero2one_t[N]  sample input vector.
- s_expected  in  zero2one_t  sample target.
- start  in  1  pulse: begin training on buffered samples.
- clear  in  1  synchronous flush: empty buffer, return to IDLE.
- busy  out  1  training in progress.
- done  out  1  training finished; held until start or clear.
- epoch_done  out  1  one-cycle pulse at each epoch end.
- epoch_cnt  out  $clog2(EPOCHS+1)  epochs completed.
- epoch_err  out  ERRW  error sum of the last completed epoch.
- n_valid  out  1  to neuron `valid`.
- n_learn  out  1  to neuron `learn`.
- n_in  out  zero2one_t[N]  to neuron `in`.
- n_expected  out  zero2one_t  to neuron `expected_out`.
- n_out  in  zero2one_t  from neuron `out` (combinational path).

Behaviour:
- Reset values: s_ready=1, busy=0, done=0, epoch_done=0, epoch_cnt=0, epoch_err=0, n_valid=1, n_learn=0, n_in=0, n_expected=0. Internal state: count=0, wr_ptr=0, rd_idx=0.
- Reset mid-training aborts immediately; buffer contents are discarded (count=0).
- States: IDLE, SETTLE, EVAL, DONE.
- IDLE:
  - s_ready = (count<DEPTH).
  - s_valid & s_ready: write buf[wr_ptr]; wr_ptr++, count++.
  - Frozen neuron: n_valid=1, n_learn=0.
- start in IDLE:
  - A sample accepted in the same cycle is included.
  - count==0 → DONE next cycle with epoch_err=0 and epoch_cnt=0.
  - Otherwise → SETTLE with rd_idx=0 and the accumulator cleared.
- SETTLE:
  - n_valid=0, n_learn=1, n_in=buf[rd_idx].in, n_expected=buf[rd_idx].exp.
  - Lasts exactly SETTLE_CYC cycles, then → EVAL.
- EVAL (exactly 1 cycle):
  - n_valid=1, n_learn=1, same n_in/n_expected.
  - Register |n_out − n_expected| (unsigned difference) and add it to acc.
  - If rd_idx<count−1: rd_idx++ → SETTLE.
  - Else (epoch end):
    - epoch_err ← acc + this cycle's term; epoch_cnt++; epoch_done pulses in the following cycle.
    - If the new epoch_err ≤ ERR_TOL or epoch_cnt==EPOCHS → DONE.
    - Otherwise rd_idx=0, acc=0 → SETTLE.
- Per-sample latency is SETTLE_CYC+1 cycles. One epoch is count×(SETTLE_CYC+1) cycles.
- busy=1 in SETTLE and EVAL. s_ready=0 and start is ignored while busy.
- DONE:
  - done=1, n_valid=1, n_learn=0; buffer retained.
  - start → retrain the same buffer, with epoch_cnt and epoch_err cleared.
  - New samples are not accepted in DONE (s_ready=0).
- clear has highest priority in any state (below reset only): next cycle is IDLE, count=0, wr_ptr=0, done=0; epoch_cnt and epoch_err are cleared.
  - clear and s_valid in the same cycle: the sample is dropped.
  - clear and start in the same cycle: clear wins.
- Buffer full (count==DEPTH): s_ready=0 and nothing is written.
- Wrap-around: pointers never exceed count−1; no circular reuse.

Decomposition:
- Shared package (defs):
  - zero2one_t and frac_t (already defined there).
  - New sample_t struct {zero2one_t in[N]; zero2one_t exp}; parameterise via N or use the package default.
  - State enum train_state_t.
  - absdiff_z2o() function returning a ZW-bit unsigned difference.
- One natural sub-module: sample_buffer (DEPTH-entry register array with write pointer, count, full flag and indexed read port).

Test Plan:
- Reset: assert rst_n=0 mid-SETTLE → same-cycle async return to reset values; n_valid=1, busy=0, count=0.
- Load and replay: load 3 samples (SETTLE_CYC=2, EPOCHS=1), pulse start.
  - Required n_valid sequence: 0,0,1 ×3, each with n_in/n_expected matching the load order.
  - epoch_done pulses once; done=1 after 9 busy cycles.
- Full buffer (DEPTH=4): offer 5 samples back-to-back → s_ready falls after the 4th; the 5th is not stored; replay shows exactly 4 EVAL cycles.
- Error accumulation: stub n_out=0; 2 samples with expected=max zero2one_t (ERR_TOL=0, EPOCHS=2) → epoch_err=2×max after each epoch; epoch_cnt ends at 2; done.
- Early stop: stub n_out=n_expected, EPOCHS=16 → epoch_err=0 after epoch 1; done with epoch_cnt=1.
- Boundary events: start with count=0 → done next cycle, epoch_err=0. clear+start together during DONE → IDLE, count=0, no training.
